// File: rtl/fp_expand_pkg.sv
// fp_expand shared definitions: widths, FSM state encoding, negate helper.
// Reused by the top, its interface and the bench.
package fp_expand_pkg;

    localparam int D_W = 13;
    localparam int E_W = 3;
    localparam int F_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Two's-complement negate modulo 2^D_W when sgn is set.
    function automatic logic [D_W-1:0] apply_sign(
        input logic           sgn,
        input logic [D_W-1:0] m
    );
        return sgn ? (~m + D_W'(1)) : m;
    endfunction

endpackage

// File: rtl/fp_expand_if.sv
// fp_expand handshake bundle: input sample {s,e,f} with valid/ready,
// result out_d with valid/ready, plus busy. slave = block, master = source/sink.
interface fp_expand_if
    import fp_expand_pkg::*;
();

    logic           in_valid;
    logic           in_ready;
    logic           in_s;
    logic [E_W-1:0] in_e;
    logic [F_W-1:0] in_f;
    logic           out_valid;
    logic           out_ready;
    logic [D_W-1:0] out_d;
    logic           busy;

    modport slave (
        input  in_valid, in_s, in_e, in_f, out_ready,
        output in_ready, out_valid, out_d, busy
    );

    modport master (
        output in_valid, in_s, in_e, in_f, out_ready,
        input  in_ready, out_valid, out_d, busy
    );

endinterface

// File: rtl/fp_expand.sv
// fp_expand: rebuilds the signed linear value (S ? -1 : 1) * (F << E)
// with one left shift per clock. Ports: clk, rst (sync, active-high),
// bus (fp_expand_if.slave: in_valid/in_ready/in_s/in_e/in_f,
// out_valid/out_ready/out_d, busy).
// Optional: FP_EXPAND_MIDPOINT_EN adds 1<<(E-1) before negation so the
// result is the midpoint of the quantisation interval.
module fp_expand
    import fp_expand_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fp_expand_if.slave  bus
);

    state_t         state;
    state_t         state_nx;
    logic [D_W-1:0] mag;
    logic [D_W-1:0] mag_nx;
    logic [E_W-1:0] cnt;
    logic [E_W-1:0] cnt_nx;
    logic           sgn;
    logic           sgn_nx;
    logic [D_W-1:0] out_d;
    logic [D_W-1:0] out_d_nx;
    logic           out_valid;
    logic           out_valid_nx;
    logic [D_W-1:0] fin_mag;

`ifdef FP_EXPAND_MIDPOINT_EN
    // Original exponent kept so the rounding offset is known once cnt is 0.
    logic [E_W-1:0] exp_q;
    logic [E_W-1:0] exp_nx;
    logic [D_W-1:0] half;

    assign half    = (exp_q != '0) ? (D_W'(1) << (exp_q - 1'b1)) : '0;
    assign fin_mag = mag + half;
`else
    assign fin_mag = mag;
`endif

    always_comb begin
        state_nx     = state;
        mag_nx       = mag;
        cnt_nx       = cnt;
        sgn_nx       = sgn;
        out_d_nx     = out_d;
        out_valid_nx = out_valid;
`ifdef FP_EXPAND_MIDPOINT_EN
        exp_nx       = exp_q;
`endif
        unique case (1'b1)
            (state == ST_IDLE): begin
                if (bus.in_valid) begin
                    mag_nx   = D_W'(bus.in_f);
                    cnt_nx   = bus.in_e;
                    sgn_nx   = bus.in_s;
`ifdef FP_EXPAND_MIDPOINT_EN
                    exp_nx   = bus.in_e;
`endif
                    state_nx = ST_SHIFT;
                end
            end
            (state == ST_SHIFT): begin
                if (cnt != '0) begin
                    mag_nx = mag << 1;
                    cnt_nx = cnt - 1'b1;
                end else begin
                    // F=0 negates to 0, so there is no negative zero.
                    out_d_nx     = apply_sign(sgn, fin_mag);
                    out_valid_nx = 1'b1;
                    state_nx     = ST_HOLD;
                end
            end
            (state == ST_HOLD): begin
                if (bus.out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = ST_IDLE;
                end
            end
            default: begin
                state_nx     = ST_IDLE;
                out_valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mag       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            out_d     <= '0;
            out_valid <= 1'b0;
`ifdef FP_EXPAND_MIDPOINT_EN
            exp_q     <= '0;
`endif
        end else begin
            state     <= state_nx;
            mag       <= mag_nx;
            cnt       <= cnt_nx;
            sgn       <= sgn_nx;
            out_d     <= out_d_nx;
            out_valid <= out_valid_nx;
`ifdef FP_EXPAND_MIDPOINT_EN
            exp_q     <= exp_nx;
`endif
        end
    end

    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.busy      = (state == ST_SHIFT) || (state == ST_HOLD);
    assign bus.out_valid = out_valid;
    assign bus.out_d     = out_d;

endmodule
